// File: rtl/aes128_decrypt.sv
// AES-128 iterative decryptor: forward key expansion, then one round per cycle.
// Optional key cache enabled by defining AES128_DEC_KEYCACHE_EN.
module aes128_decrypt (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic         ready
);

    typedef enum logic [1:0] {IDLE, EXPAND, DECRYPT, DONE} fsm_e;

    fsm_e         fsm_q, fsm_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rk_q, rk_d;
    logic [127:0] out_q, out_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [3:0]   cnt_q, cnt_d;
    logic         ready_q, ready_d;
`ifdef AES128_DEC_KEYCACHE_EN
    logic [127:0] ckey_q, ckey_d;
    logic [127:0] crk_q, crk_d;
    logic         cvld_q, cvld_d;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] b);
        logic [7:0] t;
        t = b ^ 8'h1b;
        return b[0] ? {1'b1, t[7:1]} : {1'b0, b[7:1]};
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                          input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = xtime(x);
        end
        return r;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128, and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] sq;
        r  = 8'h01;
        sq = a;
        for (int i = 0; i < 7; i++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        return gf_inv(rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_rot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
    endfunction

    function automatic logic [127:0] fwd_key(input logic [127:0] k,
                                             input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3;
        w0 = k[127:96] ^ sub_rot(k[31:0]) ^ {rc, 24'h0};
        w1 = k[95:64] ^ w0;
        w2 = k[63:32] ^ w1;
        w3 = k[31:0] ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] inv_key(input logic [127:0] k,
                                             input logic [7:0]   rc);
        logic [31:0] w0, w1, w2, w3;
        w3 = k[31:0] ^ k[63:32];
        w2 = k[63:32] ^ k[95:64];
        w1 = k[95:64] ^ k[127:96];
        w0 = k[127:96] ^ sub_rot(w3) ^ {rc, 24'h0};
        return {w0, w1, w2, w3};
    endfunction

    // byte (row r, column c) sits at index 4c+r, MSB first
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] r;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int w = 0; w < 4; w++) begin
                r[127-8*(4*c+w) -: 8] =
                    inv_sbox(s[127-8*(4*((c-w+4)%4)+w) -: 8]);
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0]   a0, a1, a2, a3;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            r[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b)
                             ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            r[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e)
                             ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            r[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09)
                             ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            r[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d)
                             ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return r;
    endfunction

    logic [127:0] rk_fwd;
    logic [127:0] rk_inv;
    logic [127:0] round_sub;

    assign rk_fwd    = fwd_key(rk_q, rcon_q);
    assign rk_inv    = inv_key(rk_q, rcon_q);
    assign round_sub = inv_shift_sub(state_q) ^ rk_q;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        rk_d    = rk_q;
        out_d   = out_q;
        rcon_d  = rcon_q;
        cnt_d   = cnt_q;
        ready_d = ready_q;
`ifdef AES128_DEC_KEYCACHE_EN
        ckey_d  = ckey_q;
        crk_d   = crk_q;
        cvld_d  = cvld_q;
`endif
        unique case (fsm_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = in;
                    rk_d    = key;
                    cnt_d   = 4'd0;
                    ready_d = 1'b0;
                    rcon_d  = 8'h01;
                    fsm_d   = EXPAND;
`ifdef AES128_DEC_KEYCACHE_EN
                    if (cvld_q && key == ckey_q) begin
                        rk_d   = crk_q;
                        rcon_d = 8'h36;
                        fsm_d  = DECRYPT;
                    end else begin
                        ckey_d = key;
                        cvld_d = 1'b0;
                    end
`endif
                end
            end
            EXPAND: begin
                rk_d   = rk_fwd;
                rcon_d = xtime(rcon_q);
                cnt_d  = cnt_q + 4'd1;
                if (cnt_q == 4'd9) begin
                    cnt_d  = 4'd0;
                    rcon_d = 8'h36;
                    fsm_d  = DECRYPT;
`ifdef AES128_DEC_KEYCACHE_EN
                    crk_d  = rk_fwd;
                    cvld_d = 1'b1;
`endif
                end
            end
            DECRYPT: begin
                rk_d   = rk_inv;
                cnt_d  = cnt_q + 4'd1;
                rcon_d = (cnt_q < 4'd9) ? inv_xtime(rcon_q) : 8'h00;
                if (cnt_q == 4'd0) begin
                    state_d = state_q ^ rk_q;
                end else if (cnt_q == 4'd10) begin
                    out_d   = round_sub;
                    ready_d = 1'b1;
                    cnt_d   = 4'd0;
                    fsm_d   = DONE;
                end else begin
                    state_d = inv_mix(round_sub);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            rk_q    <= '0;
            out_q   <= '0;
            rcon_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
`ifdef AES128_DEC_KEYCACHE_EN
            ckey_q  <= '0;
            crk_q   <= '0;
            cvld_q  <= 1'b0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            rk_q    <= rk_d;
            out_q   <= out_d;
            rcon_q  <= rcon_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
`ifdef AES128_DEC_KEYCACHE_EN
            ckey_q  <= ckey_d;
            crk_q   <= crk_d;
            cvld_q  <= cvld_d;
`endif
        end
    end

    assign out   = out_q;
    assign ready = ready_q;

endmodule
